// File: rtl/vx_rsp_reorder.sv
// In-order retire stage: records tag acquisition order, absorbs out-of-order responses, retires in order.
// Optional VX_RSP_REORDER_BYPASS_EN lets a response to the head tag retire in its arrival cycle.
module vx_rsp_reorder #(
    parameter int DATAW     = 1,
    parameter int RSP_DATAW = 1,
    parameter int SIZE      = 1,
    parameter int ADDRW     = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alloc_en,
    input  logic [ADDRW-1:0]     alloc_tag,
    input  logic                 rsp_valid,
    input  logic [ADDRW-1:0]     rsp_tag,
    input  logic [RSP_DATAW-1:0] rsp_data,
    output logic                 rsp_ready,
    output logic [ADDRW-1:0]     read_addr,
    input  logic [DATAW-1:0]     meta_data,
    output logic                 release_en,
    output logic                 out_valid,
    output logic [DATAW-1:0]     out_meta,
    output logic [RSP_DATAW-1:0] out_data,
    input  logic                 out_ready,
    output logic [ADDRW:0]       pending
);
    localparam logic [ADDRW-1:0] LAST = ADDRW'(SIZE - 1);
    localparam logic [ADDRW:0]   FULL = (ADDRW+1)'(SIZE);

    logic [ADDRW-1:0]     ord_q   [SIZE];
    logic [ADDRW-1:0]     ord_d   [SIZE];
    logic [RSP_DATAW-1:0] store_q [SIZE];
    logic [RSP_DATAW-1:0] store_d [SIZE];
    logic [SIZE-1:0]      done_q, done_d;
    logic [ADDRW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [ADDRW:0]       count_q, count_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATAW-1:0]     out_meta_q, out_meta_d;
    logic [RSP_DATAW-1:0] out_data_q, out_data_d;

    logic [ADDRW-1:0] head_tag;
    logic             has_head, out_free, bypass, pop;

    // Explicit compare keeps wrap correct for non-power-of-two SIZE.
    function automatic logic [ADDRW-1:0] wrap_inc(input logic [ADDRW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign head_tag = ord_q[head_q];
    assign has_head = (count_q != '0);
    assign out_free = !out_valid_q || out_ready;

`ifdef VX_RSP_REORDER_BYPASS_EN
    assign bypass = rsp_valid && (rsp_tag == head_tag) && has_head && out_free;
`else
    assign bypass = 1'b0;
`endif

    assign pop = has_head && (done_q[head_tag] || bypass) && out_free;

    always_comb begin
        ord_d       = ord_q;
        store_d     = store_q;
        done_d      = done_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_meta_d  = out_meta_q;
        out_data_d  = out_data_q;

        if (alloc_en) begin
            ord_d[tail_q] = alloc_tag;
            tail_d        = wrap_inc(tail_q);
        end

        if (pop) begin
            head_d           = wrap_inc(head_q);
            done_d[head_tag] = 1'b0;
            out_valid_d      = 1'b1;
            out_meta_d       = meta_data;
            out_data_d       = bypass ? rsp_data : store_q[head_tag];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // A bypassed response never touches the store or done vector.
        if (rsp_valid && !bypass) begin
            store_d[rsp_tag] = rsp_data;
            done_d[rsp_tag]  = 1'b1;
        end

        case ({alloc_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_meta_q  <= '0;
            out_data_q  <= '0;
        end else begin
            done_q      <= done_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_meta_q  <= out_meta_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        ord_q   <= ord_d;
        store_q <= store_d;
    end

    assign rsp_ready  = 1'b1;
    assign read_addr  = has_head ? head_tag : '0;
    assign release_en = pop;
    assign out_valid  = out_valid_q;
    assign out_meta   = out_meta_q;
    assign out_data   = out_data_q;
    assign pending    = count_q;

`ifndef SYNTHESIS
    logic [SIZE-1:0] outst_q, outst_d;

    always_comb begin
        outst_d = outst_q;
        if (pop)      outst_d[head_tag]  = 1'b0;
        if (alloc_en) outst_d[alloc_tag] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) outst_q <= '0;
        else        outst_q <= outst_d;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(alloc_en && count_q == FULL));
    a_rsp_outstanding: assert property (@(posedge clk) disable iff (!reset)
        rsp_valid |-> outst_q[rsp_tag]);
    a_rsp_not_dup: assert property (@(posedge clk) disable iff (!reset)
        rsp_valid |-> !done_q[rsp_tag]);
`endif

endmodule

// File: tb/tb_vx_rsp_reorder.sv
// Randomized bench for vx_rsp_reorder against an in-order retire reference model.
module tb_vx_rsp_reorder;
  localparam int SIZE = 4, DATAW = 8, RSP_DATAW = 16, ADDRW = 2;
`ifdef VX_RSP_REORDER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0;
  logic alloc_en = 0, rsp_valid = 0, out_ready = 0;
  logic [ADDRW-1:0] alloc_tag = '0, rsp_tag = '0;
  logic [RSP_DATAW-1:0] rsp_data = '0;
  logic rsp_ready, release_en, out_valid;
  logic [ADDRW-1:0] read_addr;
  logic [DATAW-1:0] meta_data, out_meta;
  logic [RSP_DATAW-1:0] out_data;
  logic [ADDRW:0] pending;

  logic [DATAW-1:0] meta_tb [SIZE];
  assign meta_data = meta_tb[read_addr];

  vx_rsp_reorder #(.DATAW(DATAW), .RSP_DATAW(RSP_DATAW), .SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .alloc_en(alloc_en), .alloc_tag(alloc_tag),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .read_addr(read_addr), .meta_data(meta_data), .release_en(release_en),
    .out_valid(out_valid), .out_meta(out_meta), .out_data(out_data),
    .out_ready(out_ready), .pending(pending)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // driver state
  int free_q[$];
  int unrsp[$];
  logic [DATAW-1:0] seq = '0;
  int last_tag;

  // reference model: allocation order, per-tag response status, output register
  int ord_m[$];
  bit [SIZE-1:0] done_m = '0;
  logic [RSP_DATAW-1:0] data_m [SIZE];
  bit ov_m = 0;
  logic [DATAW-1:0] om_meta, exp_seq = '0;
  logic [RSP_DATAW-1:0] om_data;
  int nrel = 0, nout = 0;
  int mh;
  bit mbyp, mpop;

  always @(negedge clk) begin
    if (!reset) begin
      ord_m.delete(); done_m = '0; ov_m = 0; exp_seq = seq;
    end else begin
      chk("pending", 32'(pending), 32'(ord_m.size()));
      chk("out_valid", 32'(out_valid), 32'(ov_m));
      if (ov_m) begin
        chk("out_meta", 32'(out_meta), 32'(om_meta));
        chk("out_data", 32'(out_data), 32'(om_data));
      end
      if (out_valid && out_ready) begin
        chk("order", 32'(out_meta), 32'(exp_seq));
        exp_seq++; nout++;
      end
      mh   = (ord_m.size() != 0) ? ord_m[0] : 0;
      mbyp = BYP && rsp_valid && (int'(rsp_tag) == mh) && (ord_m.size() != 0);
      mpop = (ord_m.size() != 0) && (done_m[mh] || mbyp) && (!ov_m || out_ready);
      chk("release_en", 32'(release_en), 32'(mpop));
      if (mpop) chk("read_addr", 32'(read_addr), 32'(mh));
      if (release_en) nrel++;
      if (mpop) begin
        om_meta = meta_tb[mh];
        om_data = mbyp ? rsp_data : data_m[mh];
        ov_m = 1; done_m[mh] = 0;
        void'(ord_m.pop_front());
        free_q.push_back(mh);
      end else if (out_ready) ov_m = 0;
      if (rsp_valid && !(mpop && mbyp)) begin
        data_m[rsp_tag] = rsp_data; done_m[rsp_tag] = 1;
      end
      if (alloc_en) ord_m.push_back(int'(alloc_tag));
    end
  end

  function automatic bit take_unrsp(input int t);
    for (int i = 0; i < unrsp.size(); i++)
      if (unrsp[i] == t) begin unrsp.delete(i); return 1'b1; end
    return 1'b0;
  endfunction

  // one cycle: optionally allocate the next free tag and/or respond to tag rt
  task automatic cyc(input bit a, input bit r, input int rt, input bit ordy);
    alloc_en = 0; rsp_valid = 0; out_ready = ordy;
    if (a && free_q.size() != 0) begin
      alloc_tag = ADDRW'(free_q.pop_front());
      alloc_en = 1; meta_tb[alloc_tag] = seq; seq++; last_tag = int'(alloc_tag);
    end
    if (r && take_unrsp(rt)) begin
      rsp_valid = 1; rsp_tag = ADDRW'(rt); rsp_data = RSP_DATAW'($urandom);
    end
    @(posedge clk); #1;
    if (alloc_en) unrsp.push_back(int'(alloc_tag));
    alloc_en = 0; rsp_valid = 0;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, ordy);
  endtask

  int t[4];
  int r0, o0;
  logic [RSP_DATAW-1:0] d0;

  initial begin
    for (int i = 0; i < SIZE; i++) begin meta_tb[i] = '0; free_q.push_back(i); end
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_meta", 32'(out_meta), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_release", 32'(release_en), 0);
    chk("rst_read_addr", 32'(read_addr), 0);
    chk("rsp_ready", 32'(rsp_ready), 1);
    @(posedge clk); #1 reset = 1;

    // in-order responses
    r0 = nrel; o0 = nout;
    for (int i = 0; i < 3; i++) begin cyc(1, 0, 0, 1); t[i] = last_tag; end
    for (int i = 0; i < 3; i++) cyc(0, 1, t[i], 1);
    idle(4, 1);
    chk("t1_releases", 32'(nrel - r0), 3);
    chk("t1_outputs", 32'(nout - o0), 3);

    // out-of-order responses 2,0,1
    r0 = nrel; o0 = nout;
    for (int i = 0; i < 3; i++) begin cyc(1, 0, 0, 1); t[i] = last_tag; end
    cyc(0, 1, t[2], 1); cyc(0, 1, t[0], 1); cyc(0, 1, t[1], 1);
    idle(4, 1);
    chk("t2_releases", 32'(nrel - r0), 3);
    chk("t2_outputs", 32'(nout - o0), 3);

    // full queue with backpressure
    r0 = nrel; o0 = nout;
    for (int i = 0; i < 4; i++) begin cyc(1, 0, 0, 0); t[i] = last_tag; end
    cyc(0, 1, t[0], 0); d0 = rsp_data;
    for (int i = 1; i < 4; i++) cyc(0, 1, t[i], 0);
    idle(5, 0);
    chk("t3_one_release", 32'(nrel - r0), 1);
    chk("t3_stall_valid", 32'(out_valid), 1);
    chk("t3_stall_data", 32'(out_data), 32'(d0));
    idle(6, 1);
    chk("t3_outputs", 32'(nout - o0), 4);

    // alloc and pop overlapping, pointers wrap
    o0 = nout;
    for (int i = 0; i <= 10; i++) cyc(i < 10, i > 0, last_tag, 1);
    idle(5, 1);
    chk("wrap_outputs", 32'(nout - o0), 10);

    // random traffic
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 1) == 0, (unrsp.size() != 0) && ($urandom_range(0, 1) == 0),
          (unrsp.size() != 0) ? unrsp[$urandom_range(0, unrsp.size() - 1)] : 0,
          $urandom_range(0, 3) != 0);
    for (int i = 0; i < SIZE && unrsp.size() != 0; i++) cyc(0, 1, unrsp[0], 1);
    idle(8, 1);
    chk("rand_all_retired", 32'(exp_seq), 32'(seq));
    chk("rand_pending", 32'(pending), 0);

    // reset with tags pending and output valid
    for (int i = 0; i < 3; i++) begin cyc(1, 0, 0, 0); t[i] = last_tag; end
    cyc(0, 1, t[0], 0);
    idle(2, 0);
    chk("pre_rst_valid", 32'(out_valid), 1);
    reset = 0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_pending", 32'(pending), 0);
    chk("mid_rst_release", 32'(release_en), 0);
    @(posedge clk); #1;
    free_q.delete(); unrsp.delete();
    for (int i = 0; i < SIZE; i++) free_q.push_back(i);
    reset = 1;
    o0 = nout;
    cyc(1, 0, 0, 1); t[0] = last_tag;
    chk("post_rst_tag", 32'(t[0]), 0);
    cyc(0, 1, t[0], 1);
    idle(4, 1);
    chk("post_rst_output", 32'(nout - o0), 1);
    chk("post_rst_pending", 32'(pending), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
